lcd_24_to_8_bits_pixel_serializer: RTL and testbench
====================================================

# lcd_24_to_8_bits_pixel_serializer

Upstream stage of the 24-to-8-bit LCD format adapter. Accepts one 24-bit RGB pixel per Avalon-ST beat and emits it as three 8-bit beats, which feed the adapter's byte datapath and its 1-entry data RAM write port. Packet framing is preserved: startofpacket goes on the first byte of the first pixel, and endofpacket goes on the last byte of the last pixel. Full throughput is 1 byte/clk, so a sustained pixel stream reaches 1 pixel every 3 clk with no bubbles.

## Interface
- BYTE_ORDER, 0: 0 = bits [23:16] first (R,G,B); 1 = bits [7:0] first (B,G,R)
- CNT_WIDTH, 16: width of pixel_count
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- in_data  in  24  pixel
- in_valid  in  1  sink valid
- in_startofpacket  in  1  first pixel of frame
- in_endofpacket  in  1  last pixel of frame
- in_ready  out  1  sink ready, ready latency 0
- out_data  out  8  byte
- out_valid  out  1  source valid
- out_startofpacket  out  1  first byte of frame
- out_endofpacket  out  1  last byte of frame
- out_ready  in  1  source ready, ready latency 0
- pixel_count  out  CNT_WIDTH  pixels fully emitted since reset/SOP

## Operation
- Storage: 24-bit hold register, sop/eop flags, 2-bit state.
- States:
  - EMPTY: nothing held.
  - BYTE0, BYTE1, BYTE2: index of the byte currently presented.
- Pixel accept happens when in_valid && in_ready.
  - Loads hold, sop and eop.
  - Next state is BYTE0.
- Byte transfer happens when out_valid && out_ready.
  - BYTE0 → BYTE1 → BYTE2.
  - From BYTE2: accept in the same cycle → BYTE0 with the new pixel; no accept → EMPTY.
- No transfer means the state holds and all out_* are stable (Avalon-ST hold rule).
- in_ready = ready_en && (state==EMPTY || (state==BYTE2 && out_ready)).
  - This is a combinational path from out_ready; it is intentional.
- ready_en is a register: 0 in reset, set to 1 on the first clk after reset_n deasserts.
- out_valid = (state != EMPTY).
- out_data is muxed from hold by state and BYTE_ORDER.
  - BYTE_ORDER=0: BYTE0=hold[23:16], BYTE1=hold[15:8], BYTE2=hold[7:0].
  - BYTE_ORDER=1: BYTE0=hold[7:0], BYTE1=hold[15:8], BYTE2=hold[23:16].
- out_startofpacket = sop && state==BYTE0.
- out_endofpacket = eop && state==BYTE2.
- pixel_count:
  - Increments on the BYTE2 transfer and wraps modulo 2^CNT_WIDTH.
  - On accept of an SOP pixel it clears to 0. If this coincides with a BYTE2 transfer, the clear wins.
- in_data is ignored while in_valid=0; in_valid is don't-care while in_ready=0.
- Reset values:
  - state=EMPTY, hold=0, sop=0, eop=0, ready_en=0, pixel_count=0.
  - Outputs: out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, in_ready=0.
- Reset mid-pixel: bytes not yet emitted are discarded. No partial pixel is emitted after reset.
- Pixel with both SOP and EOP: sop appears on BYTE0 and eop on BYTE2.
- An SOP arriving without a preceding EOP is passed through unchanged; no framing repair.

## Timing
- Latency: pixel accepted on edge n → BYTE0 valid after edge n (visible in cycle n+1).
- Bytes of one pixel go out on consecutive cycles when out_ready=1.
- Back-to-back pixels: the next pixel is accepted on the cycle its predecessor's BYTE2 transfers, so there is no idle cycle.
- Throughput: 3 clk per pixel with out_ready held at 1.
- With out_ready=0, out_data is held indefinitely and in_ready=0 (except in EMPTY).
- First accept after reset: earliest on the second clk edge after reset_n rises (in_ready goes high after the first edge).

## Test plan
- Reset hold:
  - Stimulus: reset_n=0, in_valid=1.
  - Required: in_ready=0, out_valid=0, out_data=0, pixel_count=0.
  - After release: in_ready=1 after the first edge.
- Single pixel, BYTE_ORDER=0:
  - Stimulus: in_data=24'hA1B2C3, sop=eop=1, out_ready=1.
  - Required: bytes A1(sop), B2, C3(eop) on 3 consecutive cycles; then out_valid=0; pixel_count=1.
- Streaming:
  - Stimulus: 4 pixels 010203, 040506, 070809, 0A0B0C, continuous valid, out_ready=1.
  - Required: 12 bytes 01..0C with no bubbles; in_ready high exactly on the BYTE2 cycles; pixel_count=4.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,0,1 during pixel 112233.
  - Required: byte stays stable while out_ready=0; exactly 11,22,33 emitted; no new accept before the 33 transfer.
- BYTE_ORDER=1 with wrap:
  - Stimulus: BYTE_ORDER=1, CNT_WIDTH=2, 5 pixels of value 123456.
  - Required: each pixel emits 56,34,12; pixel_count sequence 1,2,3,0,1.
- Reset mid-pixel:
  - Stimulus: assert reset_n=0 after byte 11 of pixel 112233.
  - Required: 22 and 33 are never emitted.
  - Then: next pixel 445566 (sop) emits 44(sop),55,66; pixel_count=1.

Source files
------------

// File: rtl/lcd_24_to_8_bits_pixel_serializer.sv
// Splits each 24-bit Avalon-ST pixel into three 8-bit beats, preserving packet framing.
// Bytes leave at 1/clk; the next pixel is accepted on the cycle the last byte leaves.
module lcd_24_to_8_bits_pixel_serializer #(
    parameter int BYTE_ORDER = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [23:0]          in_data,
    input  logic                 in_valid,
    input  logic                 in_startofpacket,
    input  logic                 in_endofpacket,
    output logic                 in_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] pixel_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        BYTE2 = 2'd3
    } state_t;

    state_t                r_state;
    logic [23:0]           r_hold;
    logic                  r_sop;
    logic                  r_eop;
    logic                  r_ready_en;
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  w_accept;
    logic                  w_xfer;

    // in_ready depends combinationally on out_ready so a new pixel can load
    // in the same cycle the last byte of the previous one leaves.
    assign in_ready  = r_ready_en && ((r_state == EMPTY) || ((r_state == BYTE2) && out_ready));
    assign out_valid = (r_state != EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = out_valid && out_ready;

    always_comb begin
        out_data = r_hold[23:16];
        case (r_state)
            BYTE0:   out_data = (BYTE_ORDER == 0) ? r_hold[23:16] : r_hold[7:0];
            BYTE1:   out_data = r_hold[15:8];
            BYTE2:   out_data = (BYTE_ORDER == 0) ? r_hold[7:0] : r_hold[23:16];
            default: out_data = r_hold[23:16];
        endcase
    end

    assign out_startofpacket = r_sop && (r_state == BYTE0);
    assign out_endofpacket   = r_eop && (r_state == BYTE2);
    assign pixel_count       = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= EMPTY;
            r_hold     <= '0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_ready_en <= 1'b0;
            r_count    <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_hold  <= in_data;
                r_sop   <= in_startofpacket;
                r_eop   <= in_endofpacket;
                r_state <= BYTE0;
            end else if (w_xfer) begin
                case (r_state)
                    BYTE0:   r_state <= BYTE1;
                    BYTE1:   r_state <= BYTE2;
                    default: r_state <= EMPTY;
                endcase
            end
            // A new frame restarts the count even if a pixel completes this cycle.
            if (w_accept && in_startofpacket)
                r_count <= '0;
            else if (w_xfer && (r_state == BYTE2))
                r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_24_to_8_bits_pixel_serializer.sv
// Bench for the pixel serializer: two instances (MSB-first/16-bit count and
// LSB-first/2-bit count) share stimulus and are checked against a byte-queue model.
module tb_lcd_24_to_8_bits_pixel_serializer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, out_sop0, out_eop0;
    logic [7:0]  out_data0;
    logic [15:0] pixel_count0;
    logic        in_ready1, out_valid1, out_sop1, out_eop1;
    logic [7:0]  out_data1;
    logic [1:0]  pixel_count1;

    always #5 clk = ~clk;

    lcd_24_to_8_bits_pixel_serializer #(.BYTE_ORDER(0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_startofpacket(out_sop0),
        .out_endofpacket(out_eop0), .out_ready(out_ready), .pixel_count(pixel_count0)
    );

    lcd_24_to_8_bits_pixel_serializer #(.BYTE_ORDER(1), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_startofpacket(out_sop1),
        .out_endofpacket(out_eop1), .out_ready(out_ready), .pixel_count(pixel_count1)
    );

    // Model: every accepted pixel becomes three pending bytes; at most one pixel is held.
    typedef struct {
        logic [23:0] px;
        int          idx;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t       q[$];
    logic [31:0] m_cnt = '0;
    logic        m_ren = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [7:0] byte_of(input logic [23:0] px, input int idx, input int order);
        int sh;
        sh = (order == 0) ? (2 - idx) * 8 : idx * 8;
        return 8'((px >> sh) & 24'hFF);
    endfunction

    task automatic assert_reset();
        reset_n = 1'b0;
        q.delete();
        m_cnt = '0;
        m_ren = 1'b0;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the model at the edge.
    task automatic step(input logic v, input logic [23:0] d, input logic s, input logic e,
                        input logic ro, output logic acc);
        beat_t h;
        logic  er, xfer;
        in_valid = v; in_data = d; in_sop = s; in_eop = e; out_ready = ro;
        @(negedge clk);
        er = m_ren && ((q.size() == 0) || ((q.size() == 1) && ro));
        n_cmp++;
        if (in_ready0 !== er || in_ready1 !== er) begin
            n_err++;
            $display("FAIL in_ready: got %b/%b required %b", in_ready0, in_ready1, er);
        end
        n_cmp++;
        if (out_valid0 !== (q.size() != 0) || out_valid1 !== (q.size() != 0)) begin
            n_err++;
            $display("FAIL out_valid: got %b/%b required %b", out_valid0, out_valid1, q.size() != 0);
        end
        if (q.size() != 0) begin
            h = q[0];
            n_cmp++;
            if (out_data0 !== byte_of(h.px, h.idx, 0) || out_data1 !== byte_of(h.px, h.idx, 1)) begin
                n_err++;
                $display("FAIL out_data: got %h/%h required %h/%h", out_data0, out_data1,
                         byte_of(h.px, h.idx, 0), byte_of(h.px, h.idx, 1));
            end
            n_cmp++;
            if (out_sop0 !== (h.sop && h.idx == 0) || out_sop1 !== (h.sop && h.idx == 0) ||
                out_eop0 !== (h.eop && h.idx == 2) || out_eop1 !== (h.eop && h.idx == 2)) begin
                n_err++;
                $display("FAIL framing: got sop %b/%b eop %b/%b required sop %b eop %b",
                         out_sop0, out_sop1, out_eop0, out_eop1, h.sop && h.idx == 0, h.eop && h.idx == 2);
            end
        end
        n_cmp++;
        if (pixel_count0 !== m_cnt[15:0] || pixel_count1 !== m_cnt[1:0]) begin
            n_err++;
            $display("FAIL pixel_count: got %0d/%0d required %0d/%0d", pixel_count0, pixel_count1,
                     m_cnt[15:0], m_cnt[1:0]);
        end
        xfer = (q.size() != 0) && ro;
        acc  = v && er;
        if (xfer) begin
            h = q.pop_front();
            if (h.idx == 2) m_cnt = m_cnt + 1;
        end
        if (acc) begin
            if (s) m_cnt = '0;
            for (int i = 0; i < 3; i++) q.push_back('{px: d, idx: i, sop: s, eop: e});
        end
        @(posedge clk);
        if (reset_n) m_ren = 1'b1;
        #1;
    endtask

    task automatic drain(input int n);
        logic acc;
        repeat (n) step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic test_reset();
        logic acc;
        assert_reset();
        step(1'b1, 24'hFFFFFF, 1'b1, 1'b1, 1'b1, acc);
        step(1'b1, 24'hFFFFFF, 1'b1, 1'b1, 1'b1, acc);
        n_cmp++;
        if (out_data0 !== 8'h00 || out_data1 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_out_data: got %h/%h required 00", out_data0, out_data1);
        end
        reset_n = 1'b1;
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, acc);   // in_ready still 0 before the first edge
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, acc);   // in_ready 1 after it
    endtask

    task automatic test_single();
        logic acc;
        step(1'b1, 24'hA1B2C3, 1'b1, 1'b1, 1'b1, acc);
        n_cmp++;
        if (acc !== 1'b1) begin
            n_err++;
            $display("FAIL single_accept: got %b required 1", acc);
        end
        drain(4);
        n_cmp++;
        if (pixel_count0 !== 16'd1) begin
            n_err++;
            $display("FAIL single_count: got %0d required 1", pixel_count0);
        end
    endtask

    task automatic test_stream();
        logic [23:0] px [4] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
        logic acc;
        int k = 0;
        int cyc = 0;
        while (k < 4 && cyc < 40) begin
            step(1'b1, px[k], k == 0, k == 3, 1'b1, acc);
            if (acc) k++;
            cyc++;
        end
        n_cmp++;
        if (cyc !== 10) begin   // first accept, then one accept every 3 clk
            n_err++;
            $display("FAIL stream_cycles: got %0d required 10", cyc);
        end
        drain(4);
        n_cmp++;
        if (pixel_count0 !== 16'd4) begin
            n_err++;
            $display("FAIL stream_count: got %0d required 4", pixel_count0);
        end
    endtask

    task automatic test_backpressure();
        logic ro_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic acc;
        int   n_acc = 0;
        step(1'b1, 24'h112233, 1'b1, 1'b0, 1'b0, acc);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 24'hAABBCC, 1'b0, 1'b1, ro_seq[i], acc);
            if (acc) n_acc++;
        end
        n_cmp++;
        if (n_acc !== 1) begin   // only on the cycle 33 transfers
            n_err++;
            $display("FAIL backpressure_accepts: got %0d required 1", n_acc);
        end
        drain(4);
    endtask

    task automatic test_wrap();
        logic acc;
        int k = 0;
        int cyc = 0;
        while (k < 5 && cyc < 40) begin
            step(1'b1, 24'h123456, k == 0, k == 4, 1'b1, acc);
            if (acc) k++;
            cyc++;
        end
        drain(4);
        n_cmp++;
        if (pixel_count1 !== 2'd1 || pixel_count0 !== 16'd5) begin
            n_err++;
            $display("FAIL wrap_count: got %0d/%0d required 5/1", pixel_count0, pixel_count1);
        end
    endtask

    task automatic test_mid_reset();
        logic acc;
        step(1'b1, 24'h112233, 1'b1, 1'b1, 1'b0, acc);
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, acc);   // byte 11 leaves
        assert_reset();
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, acc);
        reset_n = 1'b1;
        step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 24'h445566, 1'b1, 1'b1, 1'b1, acc);
        drain(4);
        n_cmp++;
        if (pixel_count0 !== 16'd1) begin
            n_err++;
            $display("FAIL midreset_count: got %0d required 1", pixel_count0);
        end
    endtask

    task automatic test_random();
        logic acc;
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 24'($urandom), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0), acc);
        drain(4);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
